disp_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 19 +
 rtl/disp_prescaler.sv | 32 +++
 rtl/disp_scan.sv | 154 +++++++++++++++
 tb/tb_disp_scan.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the 4-digit 7-segment scan driver.
package disp_pkg;

  localparam int DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  // Active-low anodes: all digits off.
  localparam logic [3:0] AN_OFF = 4'hF;

  // Active-low one-hot anode pattern for a digit.
  function automatic logic [3:0] an_onehot(digit_idx_t i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// disp_prescaler: free-running 0..SCAN_DIV-1 counter; tick marks the last
// cycle of each digit slot.
module disp_prescaler #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap to zero on the last cycle of a slot.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed scan driver for a 4-digit 7-segment display.
// Double-buffered contents (pending/active) commit atomically at the frame
// boundary; each digit slot starts with one blanked gap cycle.
// Optional feature macro: DISP_SCAN_LEADING_ZERO_BLANK_EN (leading-zero
// blanking applied to the enable mask at commit).
//
// LOAD is a single-cycle strobe with no back-pressure: every cycle LOAD is
// high the inputs are captured (last write wins); BUSY reports that the
// pending buffer still holds values awaiting the next frame boundary.
module disp_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LOAD,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic [3:0]  EN,
  output logic        BUSY,
  output logic [3:0]  AN,
  output nibble_t     HEX,
  output logic        POINT
);

  logic tick;

  disp_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  digit_idx_t  idx_q,   idx_d;
  logic [15:0] pdata_q, pdata_d;
  logic [3:0]  pdp_q,   pdp_d;
  logic [3:0]  pen_q,   pen_d;
  logic [15:0] adata_q, adata_d;
  logic [3:0]  adp_q,   adp_d;
  logic [3:0]  aen_q,   aen_d;
  logic        busy_q,  busy_d;
  logic [3:0]  an_q,    an_d;
  nibble_t     hex_q,   hex_d;
  logic        point_q, point_d;

  logic        frame_end;
  logic        commit;
  logic [15:0] src_data;
  logic [3:0]  src_dp;
  logic [3:0]  src_en;
  logic [3:0]  commit_en;

  // Commit source: a coincident LOAD bypasses the pending buffer.
  always_comb begin
    frame_end = tick && (idx_q == 2'd3);
    commit    = frame_end && (LOAD || busy_q);
    src_data  = LOAD ? DATA : pdata_q;
    src_dp    = LOAD ? DP   : pdp_q;
    src_en    = LOAD ? EN   : pen_q;
  end

`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
  logic [3:0] keep;

  // Keep digit i>=1 only if it or some higher digit is non-zero; digit 0 always kept.
  always_comb begin
    keep[3]   = (src_data[15:12] != 4'h0);
    keep[2]   = keep[3] || (src_data[11:8] != 4'h0);
    keep[1]   = keep[2] || (src_data[7:4]  != 4'h0);
    keep[0]   = 1'b1;
    commit_en = src_en & keep;
  end
`else
  // Committed enable is the requested enable unchanged.
  always_comb begin
    commit_en = src_en;
  end
`endif

  // Next-state: index, pending/active buffers, BUSY and registered outputs.
  always_comb begin
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    pdata_d = pdata_q;
    pdp_d   = pdp_q;
    pen_d   = pen_q;
    adata_d = adata_q;
    adp_d   = adp_q;
    aen_d   = aen_q;
    busy_d  = busy_q;

    if (LOAD) begin
      pdata_d = DATA;
      pdp_d   = DP;
      pen_d   = EN;
      busy_d  = 1'b1;
    end

    if (commit) begin
      adata_d = src_data;
      adp_d   = src_dp;
      aen_d   = commit_en;
      busy_d  = 1'b0;
    end

    // Outputs look at the next index/buffer so HEX/POINT change in the gap cycle.
    hex_d   = adata_d[4*idx_d +: 4];
    point_d = adp_d[idx_d];
    if (tick) begin
      an_d = AN_OFF;
    end else if (aen_d[idx_d]) begin
      an_d = an_onehot(idx_d);
    end else begin
      an_d = AN_OFF;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      pdata_q <= '0;
      pdp_q   <= '0;
      pen_q   <= '0;
      adata_q <= '0;
      adp_q   <= '0;
      aen_q   <= '0;
      busy_q  <= 1'b0;
      an_q    <= AN_OFF;
      hex_q   <= '0;
      point_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      pdata_q <= pdata_d;
      pdp_q   <= pdp_d;
      pen_q   <= pen_d;
      adata_q <= adata_d;
      adp_q   <= adp_d;
      aen_q   <= aen_d;
      busy_q  <= busy_d;
      an_q    <= an_d;
      hex_q   <= hex_d;
      point_q <= point_d;
    end
  end

  assign BUSY  = busy_q;
  assign AN    = an_q;
  assign HEX   = hex_q;
  assign POINT = point_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: directed bench for disp_scan with SCAN_DIV=4.
// cyc counts rising edges since reset release; slot edges are multiples of 4,
// frame boundaries multiples of 16. Samples are taken 1 time unit after edges.
module tb_disp_scan;

  localparam int SCAN_DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        LOAD  = 1'b0;
  logic [15:0] DATA  = '0;
  logic [3:0]  DP    = '0;
  logic [3:0]  EN    = '0;
  logic        BUSY;
  logic [3:0]  AN;
  logic [3:0]  HEX;
  logic        POINT;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  disp_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .LOAD  (LOAD),
    .DATA  (DATA),
    .DP    (DP),
    .EN    (EN),
    .BUSY  (BUSY),
    .AN    (AN),
    .HEX   (HEX),
    .POINT (POINT)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    DATA = d;
    DP   = p;
    EN   = e;
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  // Expect all-dark output and idle BUSY through edge n.
  task automatic check_dark(input int n);
    for (int k = 1; k <= n; k++) begin
      run_to(k);
      check("dark_an", AN, 4'hF);
      check("dark_busy", BUSY, 1'b0);
    end
  endtask

  // Expect one full frame starting with digit 0's gap at edge base.
  task automatic check_frame(input int base, input logic [15:0] d,
                             input logic [3:0] p, input logic [3:0] e);
    logic [3:0] one;
    logic [3:0] exp_an;
    int dg;
    one = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      run_to(base + k);
      dg = k / 4;
      if (k % 4 == 0)   exp_an = 4'hF;
      else if (e[dg])   exp_an = ~(one << dg);
      else              exp_an = 4'hF;
      check("frame_an", AN, exp_an);
      check("frame_hex", HEX, d[4*dg +: 4]);
      check("frame_point", POINT, p[dg]);
      check("frame_busy", BUSY, 1'b0);
    end
  endtask

  initial begin
    // Reset: asynchronous, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", AN, 4'hF);
    check("rst_hex", HEX, 4'h0);
    check("rst_point", POINT, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    check_dark(16);

    // Basic load.
    run_to(17);
    do_load(16'h1234, 4'b0001, 4'b1111);
    check("load_busy_set", BUSY, 1'b1);
    run_to(31);
    check("load_busy_hold", BUSY, 1'b1);
    check_frame(32, 16'h1234, 4'b0001, 4'b1111);

    // Partial enable.
    run_to(49);
    do_load(16'hABCD, 4'b0000, 4'b0101);
    check_frame(64, 16'hABCD, 4'b0000, 4'b0101);

    // Overwrite: last write wins.
    run_to(81);
    do_load(16'h1111, 4'b0000, 4'b1111);
    check("ovw_busy1", BUSY, 1'b1);
    run_to(87);
    do_load(16'h2222, 4'b0000, 4'b1111);
    check("ovw_busy2", BUSY, 1'b1);
    check_frame(96, 16'h2222, 4'b0000, 4'b1111);

    // Coincident load at the boundary edge 112.
    do_load(16'h5555, 4'b0000, 4'b1111);
    check_frame(112, 16'h5555, 4'b0000, 4'b1111);

    // Reset mid-frame with a pending load, during digit 2 lit.
    run_to(129);
    do_load(16'h9999, 4'b0000, 4'b1111);
    run_to(137);
    check("mid_an_lit", AN, 4'hB);
    check("mid_busy", BUSY, 1'b1);
    check("mid_hex", HEX, 4'h5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", AN, 4'hF);
    check("mid_rst_hex", HEX, 4'h0);
    check("mid_rst_busy", BUSY, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    check_dark(32);

`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
    // Leading-zero blanking.
    run_to(33);
    do_load(16'h0050, 4'b0000, 4'b1111);
    check_frame(48, 16'h0050, 4'b0000, 4'b0011);
    run_to(65);
    do_load(16'h0000, 4'b0000, 4'b1111);
    check_frame(80, 16'h0000, 4'b0000, 4'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
